// File: rtl/timeout_irq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// timeout_irq_ctrl_pkg
//   Shared definitions for the timeout interrupt controller:
//     - state_e      : controller FSM encodings (IDLE / PRESENT / RESTART)
//     - CNT_W        : width of the restart-pulse counter (RESTART_LEN <= 15)
//     - clog2()      : elaboration-time ceiling log2, used to size irq_id
// ----------------------------------------------------------------------------
package timeout_irq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_RESTART = 2'd2
  } state_e;

  localparam int CNT_W = 4;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage : timeout_irq_ctrl_pkg

// File: rtl/irq_prio_enc.sv
// ----------------------------------------------------------------------------
// irq_prio_enc
//   Purely combinational fixed-priority encoder, lowest set index wins.
//   Ports:
//     req  in  N  request vector
//     idx  out W  index of the lowest set bit of req (0 when req is empty)
//     any  out 1  at least one bit of req is set
// ----------------------------------------------------------------------------
module irq_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan from the top down so the lowest set index is the last to write idx.
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = W'(i);
      end
    end
  end

endmodule : irq_prio_enc

// File: rtl/timeout_irq_ctrl.sv
// ----------------------------------------------------------------------------
// timeout_irq_ctrl
//   Collects NUM_SRC timer timeout lines, latches each rising edge as a
//   pending event and presents one unmasked event at a time as irq/irq_id.
//   On irq_ack the event is cleared and the matching timer receives a
//   RESTART_LEN-cycle restart pulse.
//   Ports:
//     clk            in   1        system clock, posedge
//     reset          in   1        asynchronous active-low reset
//     src_timeout    in   NUM_SRC  timer timeout levels (held until restarted)
//     mask_wr        in   1        strobe: load mask from mask_wdata
//     mask_wdata     in   NUM_SRC  new mask, 1 = withhold that source
//     irq            out  1        an event is being presented
//     irq_id         out  ID_W     index of presented source
//     irq_ack        in   1        consumer accepts presented event
//     timer_restart  out  NUM_SRC  one-hot restart pulse to the acked timer
//     missed         out  NUM_SRC  sticky: edge arrived while still pending
//     missed_clr     in   1        strobe: clear all missed bits
// ----------------------------------------------------------------------------
module timeout_irq_ctrl
  import timeout_irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int ID_W        = clog2(NUM_SRC),
  parameter int RESTART_LEN = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_timeout,
  input  logic               mask_wr,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  output logic [NUM_SRC-1:0] timer_restart,
  output logic [NUM_SRC-1:0] missed,
  input  logic               missed_clr
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [ID_W-1:0]      irq_id_q, irq_id_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_SRC-1:0]   src_d_q, src_d_d;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic [NUM_SRC-1:0]   mask_q, mask_d;
  logic [NUM_SRC-1:0]   missed_q, missed_d;

  logic [NUM_SRC-1:0]   rise;
  logic [NUM_SRC-1:0]   id_onehot;
  logic [NUM_SRC-1:0]   ack_clr;
  logic                 ack_take;
  logic [ID_W-1:0]      enc_idx;
  logic                 enc_any;

  assign rise     = src_timeout & ~src_d_q;
  assign ack_take = (state_q == ST_PRESENT) && irq_ack;

  // One-hot decode of the latched id; drives both the pending clear and the
  // restart pulse so they can never disagree about which source is served.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_onehot
      assign id_onehot[gi] = (irq_id_q == ID_W'(gi));
    end
  endgenerate

  assign ack_clr = ack_take ? id_onehot : '0;

  irq_prio_enc #(
    .N (NUM_SRC),
    .W (ID_W)
  ) u_prio_enc (
    .req (pending_q & ~mask_q),
    .idx (enc_idx),
    .any (enc_any)
  );

  // --------------------------------------------------------------------------
  // Event bookkeeping: edge detect, pending, mask, missed
  // --------------------------------------------------------------------------
  always_comb begin
    src_d_d   = src_timeout;
    // A rise in the ack cycle re-arms the source: set wins over clear.
    pending_d = (pending_q & ~ack_clr) | rise;
    mask_d    = mask_wr ? mask_wdata : mask_q;
    // A fresh overrun in the clear cycle survives the clear.
    missed_d  = (missed_clr ? '0 : missed_q) | (rise & pending_q);
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      irq_id_q  <= '0;
      cnt_q     <= '0;
      src_d_q   <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      missed_q  <= '0;
    end else begin
      state_q   <= state_d;
      irq_id_q  <= irq_id_d;
      cnt_q     <= cnt_d;
      src_d_q   <= src_d_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      missed_q  <= missed_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enc_any) begin
          irq_id_d = enc_idx;
          state_d  = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        // Presentation is frozen here; mask changes only affect the next pick.
        if (irq_ack) begin
          cnt_d   = CNT_W'(RESTART_LEN);
          state_d = ST_RESTART;
        end
      end
      ST_RESTART: begin
        // cnt_q counts down RESTART_LEN..1; leaving on 1 gives RESTART_LEN
        // cycles of restart pulse.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    irq           = 1'b0;
    timer_restart = '0;
    case (state_q)
      ST_PRESENT: irq           = 1'b1;
      ST_RESTART: timer_restart = id_onehot;
      default:    ;
    endcase
  end

  assign irq_id = irq_id_q;
  assign missed = missed_q;

endmodule : timeout_irq_ctrl

// File: tb/tb_timeout_irq_ctrl.sv
module tb_timeout_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] src_timeout;
  logic       mask_wr;
  logic [3:0] mask_wdata;
  logic       irq;
  logic [1:0] irq_id;
  logic       irq_ack;
  logic [3:0] timer_restart;
  logic [3:0] missed;
  logic       missed_clr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  timeout_irq_ctrl #(
    .NUM_SRC     (4),
    .ID_W        (2),
    .RESTART_LEN (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .src_timeout   (src_timeout),
    .mask_wr       (mask_wr),
    .mask_wdata    (mask_wdata),
    .irq           (irq),
    .irq_id        (irq_id),
    .irq_ack       (irq_ack),
    .timer_restart (timer_restart),
    .missed        (missed),
    .missed_clr    (missed_clr)
  );

  // Advance one clock; return 1 time unit after the edge so outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-24s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Check the full visible presentation in one go.
  task automatic chk_out(input string tag, input logic e_irq, input logic [1:0] e_id,
                         input logic [3:0] e_rst);
    chk({tag, ".irq"}, 32'(irq), 32'(e_irq));
    if (e_irq) chk({tag, ".id"}, 32'(irq_id), 32'(e_id));
    chk({tag, ".restart"}, 32'(timer_restart), 32'(e_rst));
  endtask

  initial begin
    reset       = 1'b0;
    src_timeout = 4'b0000;
    mask_wr     = 1'b0;
    mask_wdata  = 4'b0000;
    irq_ack     = 1'b0;
    missed_clr  = 1'b0;

    // ---------------- reset state ----------------
    #3;
    chk("rst.irq", 32'(irq), 32'd0);
    chk("rst.irq_id", 32'(irq_id), 32'd0);
    chk("rst.restart", 32'(timer_restart), 32'd0);
    chk("rst.missed", 32'(missed), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // ---------------- 1: single source, ack, restart ----------------
    src_timeout = 4'b0100;
    tick();
    chk("t1.pending", 32'(dut.pending_q), 32'h4);
    chk_out("t1.lat0", 1'b0, 2'd0, 4'b0000);
    tick();
    chk_out("t1.present", 1'b1, 2'd2, 4'b0000);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk_out("t1.rst1", 1'b0, 2'd0, 4'b0100);
    chk("t1.pend_clr", 32'(dut.pending_q), 32'h0);
    tick();
    chk_out("t1.rst2", 1'b0, 2'd0, 4'b0100);
    tick();
    chk_out("t1.rst_end", 1'b0, 2'd0, 4'b0000);
    tick();
    tick();
    chk_out("t1.held_no_retrig", 1'b0, 2'd0, 4'b0000);
    src_timeout = 4'b0000;
    tick();
    tick();
    chk_out("t1.drop_no_irq", 1'b0, 2'd0, 4'b0000);

    // ---------------- 2: simultaneous rises, priority ----------------
    src_timeout = 4'b1010;
    tick();
    chk("t2.pending", 32'(dut.pending_q), 32'hA);
    tick();
    chk_out("t2.first", 1'b1, 2'd1, 4'b0000);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk_out("t2.rst_a", 1'b0, 2'd0, 4'b0010);
    tick();
    tick();
    chk_out("t2.idle", 1'b0, 2'd0, 4'b0000);
    tick();
    chk_out("t2.second", 1'b1, 2'd3, 4'b0000);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk_out("t2.rst_b", 1'b0, 2'd0, 4'b1000);
    tick();
    tick();
    src_timeout = 4'b0000;
    tick();
    chk_out("t2.done", 1'b0, 2'd0, 4'b0000);

    // ---------------- 3: mask withholds presentation ----------------
    mask_wr    = 1'b1;
    mask_wdata = 4'b0001;
    tick();
    mask_wr     = 1'b0;
    src_timeout = 4'b0001;
    tick();
    tick();
    tick();
    chk_out("t3.masked", 1'b0, 2'd0, 4'b0000);
    chk("t3.pending", 32'(dut.pending_q), 32'h1);
    mask_wr    = 1'b1;
    mask_wdata = 4'b0000;
    tick();
    mask_wr = 1'b0;
    chk_out("t3.unmask0", 1'b0, 2'd0, 4'b0000);
    tick();
    chk_out("t3.unmask1", 1'b1, 2'd0, 4'b0000);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tick();
    tick();
    src_timeout = 4'b0000;
    tick();

    // ---------------- 4: missed ----------------
    src_timeout = 4'b0010;
    tick();
    src_timeout = 4'b0000;
    tick();
    chk("t4.no_miss", 32'(missed), 32'h0);
    src_timeout = 4'b0010;
    tick();
    chk("t4.missed", 32'(missed), 32'h2);
    missed_clr = 1'b1;
    tick();
    missed_clr = 1'b0;
    chk("t4.clr", 32'(missed), 32'h0);
    src_timeout = 4'b0000;
    tick();
    src_timeout = 4'b0010;
    missed_clr  = 1'b1;
    tick();
    missed_clr  = 1'b0;
    src_timeout = 4'b0000;
    chk("t4.set_beats_clr", 32'(missed), 32'h2);
    chk_out("t4.present", 1'b1, 2'd1, 4'b0000);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tick();
    tick();
    chk("t4.pend_empty", 32'(dut.pending_q), 32'h0);
    missed_clr = 1'b1;
    tick();
    missed_clr = 1'b0;

    // ---------------- 5: stray ack, mask write during PRESENT ----------------
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk_out("t5.stray_ack", 1'b0, 2'd0, 4'b0000);
    src_timeout = 4'b0100;
    tick();
    tick();
    chk_out("t5.present", 1'b1, 2'd2, 4'b0000);
    mask_wr    = 1'b1;
    mask_wdata = 4'b1111;
    tick();
    mask_wr = 1'b0;
    chk_out("t5.mask_in_present", 1'b1, 2'd2, 4'b0000);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk_out("t5.rst", 1'b0, 2'd0, 4'b0100);
    tick();
    tick();
    mask_wr    = 1'b1;
    mask_wdata = 4'b0000;
    tick();
    mask_wr     = 1'b0;
    src_timeout = 4'b0000;
    tick();

    // ---------------- 6: async reset during RESTART ----------------
    src_timeout = 4'b1001;
    tick();
    tick();
    chk_out("t6.present", 1'b1, 2'd0, 4'b0000);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk_out("t6.rst1", 1'b0, 2'd0, 4'b0001);
    chk("t6.pend_before", 32'(dut.pending_q), 32'h8);
    #2;
    reset = 1'b0;
    #1;
    chk("t6.async_restart", 32'(timer_restart), 32'h0);
    chk("t6.async_irq", 32'(irq), 32'h0);
    chk("t6.async_pending", 32'(dut.pending_q), 32'h0);
    src_timeout = 4'b0000;
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk_out("t6.after", 1'b0, 2'd0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_timeout_irq_ctrl
